// File: rtl/reg_file_wb_pkg.sv
// Shared constants and status-vector helpers for the register file / write-back
// stage and the branch logic that consumes its flags.
package reg_file_wb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int ADDR_W    = 3;

  // Packed status vector layout shared with the branch unit
  localparam int ZERO_BIT = 0;
  localparam int NEG_BIT  = 1;
  localparam int STAT_W   = 2;

  typedef logic [STAT_W-1:0] status_t;

  function automatic status_t make_status(input logic zero, input logic neg);
    status_t s;
    s           = {STAT_W{1'b0}};
    s[ZERO_BIT] = zero;
    s[NEG_BIT]  = neg;
    return s;
  endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Write-back / read-port bundle between the datapath (master) and the
// register file (slave).
interface reg_file_wb_if
  import reg_file_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  logic [WIDTH-1:0]  IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [WIDTH-1:0]  OUT1;
  logic [WIDTH-1:0]  OUT2;
  logic              ZERO;
  logic              NEG;
  logic [DEPTH-1:0]  VALID;
  logic [ADDR_W-1:0] LASTADDR;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
    input  OUT1, OUT2, ZERO, NEG, VALID, LASTADDR
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
    output OUT1, OUT2, ZERO, NEG, VALID, LASTADDR
  );

endinterface

// File: rtl/reg_file_wb_flag_reg.sv
// ZERO/NEG status register with synchronous active-low reset and load enable;
// also instantiated by the branch unit.
module flag_reg
  import reg_file_wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  status_t d,
  output status_t q
);

  status_t q_r;

  // Status holds ZERO=1/NEG=0 out of reset, loads on enable, otherwise holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= make_status(1'b1, 1'b0);
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/reg_file_wb.sv
// Register file and write-back stage: two combinational read ports with optional
// write-through forwarding, one synchronous write port, status flags and VALID mask.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int BYPASS = 1
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_wb_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam int              SLOTS   = 2**ADDR_W;

  // Full address space is declared; unused slots only ever see the reset value
  logic [WIDTH-1:0]  mem_r [SLOTS];
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  valid_set_s;
  logic [ADDR_W-1:0] lastaddr_r;
  logic              wr_ok_s;
  status_t           flag_d_s;
  status_t           flag_q_s;
  logic [WIDTH-1:0]  out1_s;
  logic [WIDTH-1:0]  out2_s;

  // Qualified write: out of reset, enabled, and to an implemented register
  always_comb begin
    wr_ok_s = RESET & bus.WRITE & ({1'b0, bus.INADDRESS} < DEPTH_C);
  end

  // One-hot decode of the destination into the VALID mask
  always_comb begin
    valid_set_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      valid_set_s[i] = (bus.INADDRESS == ADDR_W'(i));
    end
  end

  // Storage, VALID mask and last-write address
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      valid_r    <= {DEPTH{1'b0}};
      lastaddr_r <= {ADDR_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[bus.INADDRESS] <= bus.IN;
      valid_r              <= valid_r | valid_set_s;
      lastaddr_r           <= bus.INADDRESS;
    end else begin
      valid_r    <= valid_r;
      lastaddr_r <= lastaddr_r;
    end
  end

  // Flags are computed from the incoming data and captured only on a committed write
  always_comb begin
    flag_d_s = make_status(bus.IN == {WIDTH{1'b0}}, bus.IN[WIDTH-1]);
  end

  flag_reg u_flag_reg (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (wr_ok_s),
    .d     (flag_d_s),
    .q     (flag_q_s)
  );

  // Read port 1: unimplemented address reads 0, forwarding beats storage
  always_comb begin
    out1_s = {WIDTH{1'b0}};
    if ({1'b0, bus.OUT1ADDRESS} >= DEPTH_C) begin
      out1_s = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && wr_ok_s && (bus.OUT1ADDRESS == bus.INADDRESS)) begin
      out1_s = bus.IN;
    end else begin
      out1_s = mem_r[bus.OUT1ADDRESS];
    end
  end

  // Read port 2: same selection rules as port 1
  always_comb begin
    out2_s = {WIDTH{1'b0}};
    if ({1'b0, bus.OUT2ADDRESS} >= DEPTH_C) begin
      out2_s = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && wr_ok_s && (bus.OUT2ADDRESS == bus.INADDRESS)) begin
      out2_s = bus.IN;
    end else begin
      out2_s = mem_r[bus.OUT2ADDRESS];
    end
  end

  assign bus.OUT1     = out1_s;
  assign bus.OUT2     = out2_s;
  assign bus.ZERO     = flag_q_s[ZERO_BIT];
  assign bus.NEG      = flag_q_s[NEG_BIT];
  assign bus.VALID    = valid_r;
  assign bus.LASTADDR = lastaddr_r;

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Register file and write-back stage of the 8-bit single-cycle processor. It sources both ALU operands through two read ports and commits the ALU result (for example an Or result) through one synchronous write port. It also tracks two result status flags and a per-register written-since-reset mask.

## Interface
Parameters:
- WIDTH, 8, data width of every register and data port
- DEPTH, 8, number of registers; address width is log2(DEPTH) = 3
- BYPASS, 1, 1 = write-through forwarding on read ports, 0 = no forwarding

Ports:
- CLK  input  1  system clock; all state changes on its rising edge
- RESET  input  1  synchronous, active-low reset; sampled on the rising edge of CLK
- IN  input  WIDTH  write-back data (ALU result)
- INADDRESS  input  3  destination register
- WRITE  input  1  write enable
- OUT1ADDRESS  input  3  read port 1 register select (ALU operand 1)
- OUT2ADDRESS  input  3  read port 2 register select (ALU operand 2)
- OUT1  output  WIDTH  read port 1 data
- OUT2  output  WIDTH  read port 2 data
- ZERO  output  1  last committed write data was zero
- NEG  output  1  bit WIDTH-1 of the last committed write data
- VALID  output  DEPTH  bit i set = register i written since reset
- LASTADDR  output  3  address of the last committed write

## Operation
- Storage: DEPTH x WIDTH flops. All registers are writable; R0 is not hardwired.
- Reset (RESET=0 at a rising edge):
  - all registers, VALID and LASTADDR go to 0
  - ZERO goes to 1, NEG to 0
  - reset wins over a simultaneous WRITE=1
- Write commit (RESET=1, WRITE=1 at a rising edge), all in that same edge:
  - reg[INADDRESS] <= IN
  - VALID[INADDRESS] <= 1; other VALID bits hold
  - LASTADDR <= INADDRESS
  - ZERO <= (IN == 0)
  - NEG <= IN[WIDTH-1]
- WRITE=0: registers, flags, VALID and LASTADDR hold.
- Reads: OUT1 and OUT2 are combinational from their addresses. Both ports may select the same register, and either may equal INADDRESS.
- BYPASS=1: when WRITE=1, RESET=1 and OUTnADDRESS == INADDRESS, OUTn = IN in the same cycle. Otherwise OUTn = stored value.
- BYPASS=0: OUTn shows the stored value. Newly written data appears after the commit edge.
- Data is treated as raw bits; signed interpretation is only relevant to NEG.
- Out-of-range addresses cannot occur at DEPTH=8. For smaller DEPTH, writes to unused addresses are ignored and reads of them return 0.

## Timing
- Write latency: 1 edge. The data is readable from storage immediately after the commit edge.
- Read latency: 0 cycles (combinational). This holds for storage reads and for bypassed reads.
- ZERO, NEG, VALID and LASTADDR are registered. Each reflects the write committed at the most recent qualifying edge.
- Back-to-back writes to the same address: the last write wins, and the flags track each write in turn.
- Reset held for several cycles: state stays at the reset values. The first write is accepted at the first edge with RESET=1.
- Reset asserted between writes: all prior data is lost. OUT1 and OUT2 read 0 from the next cycle.

## Structure
- Shared package holds:
  - WIDTH and DEPTH defaults
  - ADDR_W = 3
  - ZERO/NEG flag bit positions, for a packed status vector used by the branch logic
- One sub-module, flag_reg: holds ZERO and NEG with reset and write-enable. It is reused later by the branch unit.
- Storage array, VALID mask, LASTADDR and the bypass muxes stay in reg_file_wb.

## Test plan
- Reset: RESET=0 for 2 edges -> OUT1=OUT2=0 for all addresses, ZERO=1, NEG=0, VALID=8'h00, LASTADDR=0.
- Writes: write 25 to R1, then 3 to R2; read OUT1ADDRESS=1, OUT2ADDRESS=2 -> OUT1=8'b00011001, OUT2=8'b00000011, VALID=8'h06, LASTADDR=2, ZERO=0, NEG=0.
- Negative value: write 8'b11111011 (-5) to R7 -> NEG=1, ZERO=0, VALID[7]=1; then write 0 to R7 -> ZERO=1, NEG=0, OUT1(addr 7)=0 after the edge.
- Bypass (BYPASS=1): stored R3=6; with WRITE=1, INADDRESS=3, IN=8'b11111110 (-2), OUT1ADDRESS=OUT2ADDRESS=3 -> both outputs 8'hFE before the edge. With BYPASS=0 the same stimulus shows 6 until the edge.
- Reset versus write: RESET=0 and WRITE=1 (IN=8, INADDRESS=4) at the same edge -> R4=0, VALID=0, ZERO=1.
- Reset mid-stream: write 1 to R5, assert reset for 1 edge, release and write 9 to R6 -> R5 reads 0, R6 reads 9, VALID=8'h40.
